imm_instr_encoder: RTL and testbench

//  Inverse of the immediate extender. Packs a signed/unsigned 32-bit immediate plus register/opcode fields into
//  RV32I instruction words for the I, S, B, U and J formats. Expands the LI pseudo-op into one or two words
//  (LUI/ADDI). Sits between the self-test program generator and the instruction-memory loader.

---
 rtl/rv_isa_pkg.sv | 26 ++
 rtl/imm_instr_encoder_if.sv | 29 ++
 rtl/imm_field_packer.sv | 52 +++++
 rtl/imm_instr_encoder.sv | 159 +++++++++++++++
 tb/tb_imm_instr_encoder.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the immediate extender and the instruction encoder.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_S  = 3'd1,
        FMT_B  = 3'd2,
        FMT_U  = 3'd3,
        FMT_J  = 3'd4,
        FMT_LI = 3'd5
    } fmt_e;

    typedef enum logic {
        ST_IDLE,
        ST_LI_LO
    } enc_state_e;

    localparam logic [6:0]  OPC_LUI   = 7'b0110111;
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
    localparam logic [31:0] NOP_WORD  = 32'h00000013;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_instr_encoder_if.sv
// Request/response stream bundle between the program generator, the encoder and the memory loader.
interface imm_instr_encoder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic             out_last;
    logic             out_err;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_last, out_err
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/imm_field_packer.sv
// Combinational packer: scatters an immediate and register fields into one RV32I word and flags
// immediates that do not fit the chosen format.
module imm_field_packer
    import rv_isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic signed [31:0] simm;

    assign simm = $signed(imm);

    always_comb begin
        word = NOP_WORD;
        err  = 1'b1;
        case (fmt)
            FMT_I: begin
                word = {imm[11:0], rs1, f3, rd, op};
                err  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                err  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                err  = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], rd, op};
                err  = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                err  = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            end
            default: begin
                word = NOP_WORD;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Stream encoder: turns immediate/register requests into RV32I words with a registered output,
// expanding LI into LUI (+ ADDI when the low 12 bits are non-zero).
module imm_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    imm_instr_encoder_if.slave bus,
    output logic [CNT_W-1:0]   word_cnt
);

    enc_state_e       state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [11:0]      lo_q, lo_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        handoff;
    logic        accept;
    logic        is_li;
    logic        li_small;
    logic        li_lo_zero;
    logic [19:0] li_hi;

    logic [2:0]  pk_fmt;
    logic [6:0]  pk_op;
    logic [2:0]  pk_f3;
    logic [4:0]  pk_rd;
    logic [4:0]  pk_rs1;
    logic [4:0]  pk_rs2;
    logic [31:0] pk_imm;
    logic [31:0] pk_word;
    logic        pk_err;

    assign handoff      = valid_q & bus.out_ready;
    assign bus.in_ready = (state_q == ST_IDLE) & (~valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    assign is_li      = (bus.in_fmt == FMT_LI);
    assign li_small   = ($signed(bus.in_imm) >= -32'sd2048) && ($signed(bus.in_imm) <= 32'sd2047);
    assign li_lo_zero = (bus.in_imm[11:0] == 12'd0);
    // Adding imm[11] compensates for the ADDI sign-extending its 12-bit operand.
    assign li_hi      = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

    always_comb begin
        pk_fmt = bus.in_fmt;
        pk_op  = bus.in_opcode;
        pk_f3  = bus.in_funct3;
        pk_rd  = bus.in_rd;
        pk_rs1 = bus.in_rs1;
        pk_rs2 = bus.in_rs2;
        pk_imm = bus.in_imm;
        if (state_q == ST_LI_LO) begin
            pk_fmt = FMT_I;
            pk_op  = OPC_OPIMM;
            pk_f3  = 3'd0;
            pk_rd  = rd_q;
            pk_rs1 = rd_q;
            pk_imm = sext12(lo_q);
        end else if (is_li) begin
            if (li_small) begin
                pk_fmt = FMT_I;
                pk_op  = OPC_OPIMM;
                pk_f3  = 3'd0;
                pk_rs1 = 5'd0;
            end else begin
                pk_fmt = FMT_U;
                pk_op  = OPC_LUI;
                pk_imm = {li_hi, 12'd0};
            end
        end
    end

    imm_field_packer u_packer (
        .fmt  (pk_fmt),
        .op   (pk_op),
        .f3   (pk_f3),
        .rd   (pk_rd),
        .rs1  (pk_rs1),
        .rs2  (pk_rs2),
        .imm  (pk_imm),
        .word (pk_word),
        .err  (pk_err)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, handoff};
        if (handoff) begin
            valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    valid_d = 1'b1;
                    instr_d = pk_word;
                    err_d   = is_li ? 1'b0 : pk_err;
                    last_d  = ~is_li | li_small | li_lo_zero;
                    if (is_li & ~li_small & ~li_lo_zero) begin
                        state_d = ST_LI_LO;
                        lo_d    = bus.in_imm[11:0];
                        rd_d    = bus.in_rd;
                    end
                end
            end
            ST_LI_LO: begin
                if (handoff) begin
                    valid_d = 1'b1;
                    instr_d = pk_word;
                    last_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= 12'd0;
            rd_q    <= 5'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;
    assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: expected words are queued on accept and popped on handoff.
module tb_imm_instr_encoder;
    import rv_isa_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic        err;
    } word_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_cnt;

    word_t       exp_q[$];
    int          n_cmp;
    int          n_bad;
    int          cyc;
    logic [15:0] cnt_model;

    imm_instr_encoder_if #(.WIDTH(32)) bus ();

    imm_instr_encoder #(.WIDTH(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .word_cnt (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.f3 = f3; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    // Reference encoder built from shifted and masked fields.
    function automatic word_t model_word(input req_t r);
        word_t       w;
        int          v;
        logic [31:0] u, opf, rdf, f3f, rs1f, rs2f;
        u = r.imm;
        v = $signed(r.imm);
        opf  = {25'd0, r.op};
        rdf  = {27'd0, r.rd} << 7;
        f3f  = {29'd0, r.f3} << 12;
        rs1f = {27'd0, r.rs1} << 15;
        rs2f = {27'd0, r.rs2} << 20;
        w.last = 1'b1;
        w.err  = 1'b0;
        case (r.fmt)
            3'd0: begin
                w.instr = opf | rdf | f3f | rs1f | ((u & 32'hFFF) << 20);
                w.err   = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                w.instr = opf | f3f | rs1f | rs2f | (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7);
                w.err   = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                w.instr = opf | f3f | rs1f | rs2f | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                        | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
                w.err   = (v < -4096) || (v > 4094) || u[0];
            end
            3'd3: begin
                w.instr = opf | rdf | (u & 32'hFFFFF000);
                w.err   = (u & 32'hFFF) != 32'd0;
            end
            3'd4: begin
                w.instr = opf | rdf | (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                        | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12);
                w.err   = (v < -1048576) || (v > 1048574) || u[0];
            end
            default: begin
                w.instr = 32'h00000013;
                w.err   = 1'b1;
            end
        endcase
        return w;
    endfunction

    function automatic void push_expected(input req_t r);
        req_t        a;
        word_t       w;
        int          v, lo;
        logic [31:0] hi;
        if (r.fmt != 3'd5) begin
            exp_q.push_back(model_word(r));
            return;
        end
        v  = $signed(r.imm);
        lo = v & 4095;
        if (lo >= 2048) lo = lo - 4096;
        a  = mk(3'd0, 7'h13, 3'd0, r.rd, 5'd0, 5'd0, r.imm);
        if (v >= -2048 && v <= 2047) begin
            exp_q.push_back(model_word(a));
        end else begin
            hi      = r.imm - 32'(lo);
            w.instr = (hi & 32'hFFFFF000) | ({27'd0, r.rd} << 7) | 32'h37;
            w.last  = (lo == 0);
            w.err   = 1'b0;
            exp_q.push_back(w);
            if (lo != 0) begin
                a.rs1 = r.rd;
                a.imm = 32'(lo);
                exp_q.push_back(model_word(a));
            end
        end
    endfunction

    // One cycle: drive at the falling edge, sample 1 ns later, queue expectations on accept.
    task automatic step(input logic rv, input req_t r, input logic ord,
                        output logic acc, output logic ho, output word_t obs);
        @(negedge clk);
        bus.in_valid  = rv;
        bus.in_fmt    = r.fmt;
        bus.in_opcode = r.op;
        bus.in_funct3 = r.f3;
        bus.in_rd     = r.rd;
        bus.in_rs1    = r.rs1;
        bus.in_rs2    = r.rs2;
        bus.in_imm    = r.imm;
        bus.out_ready = ord;
        #1;
        acc = bus.in_valid & bus.in_ready;
        ho  = bus.out_valid & bus.out_ready;
        obs = {bus.out_instr, bus.out_last, bus.out_err};
        if (acc) push_expected(r);
        if (ho) cnt_model = cnt_model + 16'd1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_fmt = 3'd0; bus.in_opcode = 7'd0;
        bus.in_funct3 = 3'd0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 32'd0;
        exp_q.delete();
        cnt_model = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_flags got v=%b l=%b e=%b expected 0 0 0", bus.out_valid, bus.out_last, bus.out_err);
        end
        n_cmp++;
        if (bus.out_instr !== 32'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_instr got %h expected 00000000", bus.out_instr);
        end
        n_cmp++;
        if (word_cnt !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_cnt got %0d expected 0", word_cnt);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_i_s_format();
        req_t  reqs[$];
        word_t got[$];
        word_t obs, e;
        logic  acc, ho;
        int    idx, acc_cyc, ho_cyc;
        reqs.push_back(mk(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5));
        reqs.push_back(mk(3'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, -32'sd4));
        reqs.push_back(mk(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048));
        idx = 0; acc_cyc = -1; ho_cyc = -1;
        for (int c = 0; c < 40 && (idx < reqs.size() || exp_q.size() != 0); c++) begin
            step(idx < reqs.size(), (idx < reqs.size()) ? reqs[idx] : '0, 1'b1, acc, ho, obs);
            if (acc && idx == 0) acc_cyc = cyc;
            if (acc) idx++;
            if (ho) begin
                if (ho_cyc < 0) ho_cyc = cyc;
                got.push_back(obs);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL i_unexpected got %h", obs.instr);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_bad++;
                        $display("[TB] FAIL i_word got %h/%b/%b expected %h/%b/%b", obs.instr, obs.last, obs.err, e.instr, e.last, e.err);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || got.size() != 3) begin
            n_bad++;
            $display("[TB] FAIL i_count got %0d words expected 3", got.size());
            exp_q.delete();
        end else begin
            n_cmp++;
            if (got[0] !== {32'h00500093, 1'b1, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL i_addi got %h/%b/%b expected 00500093/1/0", got[0].instr, got[0].last, got[0].err);
            end
            n_cmp++;
            if (got[2] !== {32'h80000093, 1'b1, 1'b1}) begin
                n_bad++;
                $display("[TB] FAIL i_range got %h/%b/%b expected 80000093/1/1", got[2].instr, got[2].last, got[2].err);
            end
        end
        n_cmp++;
        if (ho_cyc - acc_cyc != 1) begin
            n_bad++;
            $display("[TB] FAIL i_latency got %0d cycles expected 1", ho_cyc - acc_cyc);
        end
    endtask

    task automatic test_b_u_j_format();
        req_t  reqs[$];
        word_t got[$];
        word_t obs, e;
        logic  acc, ho;
        int    idx;
        reqs.push_back(mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8));
        reqs.push_back(mk(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd4));
        reqs.push_back(mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7));
        reqs.push_back(mk(3'd3, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 32'h12345000));
        reqs.push_back(mk(3'd3, 7'h17, 3'd0, 5'd3, 5'd0, 5'd0, 32'h12345001));
        reqs.push_back(mk(3'd6, 7'h33, 3'd1, 5'd4, 5'd5, 5'd6, 32'd1));
        reqs.push_back(mk(3'd4, 7'h6F, 3'd0, 5'd2, 5'd0, 5'd0, 32'h00100000));
        idx = 0;
        for (int c = 0; c < 60 && (idx < reqs.size() || exp_q.size() != 0); c++) begin
            step(idx < reqs.size(), (idx < reqs.size()) ? reqs[idx] : '0, (c % 3) != 1, acc, ho, obs);
            if (acc) idx++;
            if (ho) begin
                got.push_back(obs);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL bj_unexpected got %h", obs.instr);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_bad++;
                        $display("[TB] FAIL bj_word got %h/%b/%b expected %h/%b/%b", obs.instr, obs.last, obs.err, e.instr, e.last, e.err);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || got.size() != 7) begin
            n_bad++;
            $display("[TB] FAIL bj_count got %0d words expected 7", got.size());
            exp_q.delete();
        end else begin
            n_cmp++;
            if (got[0].instr !== 32'h00208463 || got[1].instr !== 32'hFFDFF0EF) begin
                n_bad++;
                $display("[TB] FAIL bj_beq_jal got %h %h expected 00208463 FFDFF0EF", got[0].instr, got[1].instr);
            end
            n_cmp++;
            if (got[2].err !== 1'b1 || got[4].err !== 1'b1 || got[6].err !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL bj_err got %b %b %b expected 1 1 1", got[2].err, got[4].err, got[6].err);
            end
            n_cmp++;
            if (got[5] !== {32'h00000013, 1'b1, 1'b1}) begin
                n_bad++;
                $display("[TB] FAIL bj_illegal got %h/%b/%b expected 00000013/1/1", got[5].instr, got[5].last, got[5].err);
            end
        end
    endtask

    task automatic test_li();
        req_t  reqs[$];
        word_t got[$];
        word_t obs, e;
        logic  acc, ho;
        int    idx;
        reqs.push_back(mk(3'd5, 7'h7F, 3'd7, 5'd5, 5'd9, 5'd9, 32'h12345FFF));
        reqs.push_back(mk(3'd5, 7'h7F, 3'd7, 5'd5, 5'd9, 5'd9, 32'h12345000));
        reqs.push_back(mk(3'd5, 7'h7F, 3'd7, 5'd5, 5'd9, 5'd9, 32'hFFFFFFFF));
        reqs.push_back(mk(3'd5, 7'h00, 3'd0, 5'd7, 5'd0, 5'd0, 32'h80000800));
        idx = 0;
        for (int c = 0; c < 40 && (idx < reqs.size() || exp_q.size() != 0); c++) begin
            step(idx < reqs.size(), (idx < reqs.size()) ? reqs[idx] : '0, 1'b1, acc, ho, obs);
            if (acc) idx++;
            if (ho) begin
                got.push_back(obs);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL li_unexpected got %h", obs.instr);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_bad++;
                        $display("[TB] FAIL li_word got %h/%b/%b expected %h/%b/%b", obs.instr, obs.last, obs.err, e.instr, e.last, e.err);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || got.size() != 6) begin
            n_bad++;
            $display("[TB] FAIL li_count got %0d words expected 6", got.size());
            exp_q.delete();
        end else begin
            n_cmp++;
            if (got[0] !== {32'h123462B7, 1'b0, 1'b0} || got[1] !== {32'hFFF28293, 1'b1, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL li_pair got %h/%b %h/%b expected 123462B7/0 FFF28293/1", got[0].instr, got[0].last, got[1].instr, got[1].last);
            end
            n_cmp++;
            if (got[2] !== {32'h123452B7, 1'b1, 1'b0} || got[3] !== {32'hFFF00293, 1'b1, 1'b0}) begin
                n_bad++;
                $display("[TB] FAIL li_single got %h/%b %h/%b expected 123452B7/1 FFF00293/1", got[2].instr, got[2].last, got[3].instr, got[3].last);
            end
        end
    endtask

    task automatic test_backpressure();
        word_t       obs, e;
        logic        acc, ho;
        logic [15:0] c0;
        int          seen;
        req_t        li_req, other;
        li_req = mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        other  = mk(3'd0, 7'h13, 3'd0, 5'd8, 5'd0, 5'd0, 32'd77);
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) step(1'b1, li_req, 1'b1, acc, ho, obs);
        c0 = cnt_model;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, other, 1'b0, acc, ho, obs);
            n_cmp++;
            if (obs.instr !== 32'h123462B7 || obs.last !== 1'b0 || acc !== 1'b0 || word_cnt !== c0) begin
                n_bad++;
                $display("[TB] FAIL bp_hold got %h/%b acc=%b cnt=%0d expected 123462B7/0 acc=0 cnt=%0d", obs.instr, obs.last, acc, word_cnt, c0);
            end
        end
        seen = 0;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            step(1'b0, '0, 1'b1, acc, ho, obs);
            if (ho) begin
                seen++;
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL bp_word got %h/%b/%b expected %h/%b/%b", obs.instr, obs.last, obs.err, e.instr, e.last, e.err);
                end
            end
        end
        step(1'b0, '0, 1'b1, acc, ho, obs);
        n_cmp++;
        if (seen != 2 || ho !== 1'b0 || word_cnt !== cnt_model) begin
            n_bad++;
            $display("[TB] FAIL bp_drain got words=%0d cnt=%0d expected words=2 cnt=%0d", seen, word_cnt, cnt_model);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_li();
        word_t obs;
        logic  acc, ho, saw;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) step(1'b1, mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF), 1'b0, acc, ho, obs);
        step(1'b0, '0, 1'b0, acc, ho, obs);
        n_cmp++;
        if (obs.instr !== 32'h123462B7) begin
            n_bad++;
            $display("[TB] FAIL rst_lui got %h expected 123462B7", obs.instr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_last !== 1'b0 || word_cnt !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL rst_async got v=%b instr=%h l=%b cnt=%0d expected 0 00000000 0 0", bus.out_valid, bus.out_instr, bus.out_last, word_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        cnt_model = 16'd0;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, 1'b1, acc, ho, obs);
            if (ho || bus.out_valid) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rst_no_addi got word_seen=%b in_ready=%b expected 0 1", saw, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        word_t obs, e;
        logic  acc, ho;
        int    sent, n_acc, n_ho, first_ho, last_ho;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        cnt_model = 16'd0;
        sent = 0; n_acc = 0; n_ho = 0; first_ho = -1; last_ho = -1;
        for (int c = 0; c < 40 && (sent < 16 || exp_q.size() != 0); c++) begin
            step(sent < 16, mk(3'd0, 7'h13, 3'(sent % 8), 5'(sent), 5'(31 - sent), 5'd0, 32'(sent * 300 - 2400)), 1'b1, acc, ho, obs);
            if (acc) begin
                sent++;
                n_acc++;
            end
            if (ho) begin
                n_ho++;
                if (first_ho < 0) first_ho = cyc;
                last_ho = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_unexpected got %h", obs.instr);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_bad++;
                        $display("[TB] FAIL b2b_word got %h/%b/%b expected %h/%b/%b", obs.instr, obs.last, obs.err, e.instr, e.last, e.err);
                    end
                end
            end
        end
        n_cmp++;
        if (n_ho != 16 || last_ho - first_ho != 15) begin
            n_bad++;
            $display("[TB] FAIL b2b_rate got %0d words over %0d cycles expected 16 over 15", n_ho, last_ho - first_ho);
            exp_q.delete();
        end
        step(1'b0, '0, 1'b1, acc, ho, obs);
        n_cmp++;
        if (word_cnt !== 16'd16) begin
            n_bad++;
            $display("[TB] FAIL b2b_cnt got %0d expected 16", word_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        word_t obs, e;
        logic  acc, ho;
        int    need, sent;
        req_t  r;
        r = mk(3'd0, 7'h13, 3'd0, 5'd2, 5'd2, 5'd0, 32'd1);
        need = 65535 - int'(cnt_model);
        sent = 0;
        for (int c = 0; c < 70000 && (sent < need || exp_q.size() != 0); c++) begin
            step(sent < need, r, 1'b1, acc, ho, obs);
            if (acc) sent++;
            if (ho) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL wrap_unexpected got %h", obs.instr);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_bad++;
                        $display("[TB] FAIL wrap_word got %h expected %h", obs.instr, e.instr);
                    end
                end
            end
        end
        step(1'b0, '0, 1'b1, acc, ho, obs);
        n_cmp++;
        if (word_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("[TB] FAIL wrap_full got %h expected FFFF", word_cnt);
            exp_q.delete();
        end
        sent = 0;
        for (int c = 0; c < 10 && (sent < 1 || exp_q.size() != 0); c++) begin
            step(sent < 1, r, 1'b1, acc, ho, obs);
            if (acc) sent++;
            if (ho && exp_q.size() != 0) e = exp_q.pop_front();
        end
        step(1'b0, '0, 1'b1, acc, ho, obs);
        n_cmp++;
        if (word_cnt !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL wrap_zero got %h expected 0000", word_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        test_reset();
        test_i_s_format();
        test_b_u_j_format();
        test_li();
        test_backpressure();
        test_reset_mid_li();
        test_back_to_back();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
